// File: rtl/wisc_pkg.sv
// Shared WISC pipeline definitions.
//   pipe_state_t : pipeline sequencer state encoding
//   NOP_INST     : instruction word injected when IF/ID is squashed
//   OPC_HLT      : opcode field value of the HLT instruction
package wisc_pkg;

  typedef enum logic [1:0] {RUN, STALL, FLUSH, HALT} pipe_state_t;

  localparam logic [15:0] NOP_INST = 16'h0000;
  localparam logic [3:0]  OPC_HLT  = 4'hF;

  // Opcode lives in the top nibble of every WISC instruction.
  function automatic logic is_hlt(input logic [15:0] inst);
    return inst[15:12] == OPC_HLT;
  endfunction

  function automatic logic is_nop(input logic [15:0] inst);
    return inst == NOP_INST;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
//   clk : clock
//   rst : asynchronous active-high reset, clears the count
//   inc : add one (held at all-ones once saturated)
//   clr : synchronous clear, wins over inc
//   cnt : current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central sequencer for the 5-stage WISC pipe. Turns the ID hazard, EX control-transfer
// resolution and HLT decode into PC / IF-ID enables, IF-ID flush and ID-EX bubble, owns the
// halt/unhalt handshake, and keeps a stall watchdog plus performance counters.
//   clk, rst       : clock, asynchronous active-high reset
//   hazard         : RAW hazard from the ID-stage hazard unit
//   xfer_taken     : EX resolved a taken branch/call/ret this cycle
//   halt_id        : HLT decoded in ID
//   PC_update      : unhalt request
//   perf_clr       : synchronous clear of both perf counters
//   pc_write       : PC load enable
//   ifid_write     : IF/ID load enable
//   ifid_flush     : replace IF/ID contents with a NOP
//   idex_bubble    : zero the ID/EX control fields
//   halted         : pipe halted
//   stall_timeout  : sticky, set once a stall run reaches STALL_LIMIT cycles
//   stall_cycles   : saturating count of hazard stall cycles
//   flush_count    : saturating count of accepted control transfers
module pipe_stall_ctrl
  import wisc_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned STALL_LIMIT  = 4,
  parameter int unsigned PERF_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazard,
  input  logic              xfer_taken,
  input  logic              halt_id,
  input  logic              PC_update,
  input  logic              perf_clr,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              halted,
  output logic              stall_timeout,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
);

  // The transfer cycle itself is the first squashed cycle; FLUSH covers the rest.
  localparam logic [1:0] FlushReload = 2'(FLUSH_CYCLES - 1);
  localparam logic [2:0] StallLimit  = 3'(STALL_LIMIT);

  pipe_state_t state_q, state_d;
  logic [1:0]  flush_cnt_q, flush_cnt_d;
  logic [2:0]  stall_run_q, stall_run_d;
  logic        timeout_q, timeout_d;
  // Set for the first RUN cycle after HALT: the HLT is still sitting in IF/ID.
  logic        exit_q, exit_d;
  logic        stall_inc;
  logic        flush_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      stall_run_q <= '0;
      timeout_q   <= 1'b0;
      exit_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_run_q <= stall_run_d;
      timeout_q   <= timeout_d;
      exit_q      <= exit_d;
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    halted      = 1'b0;
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    stall_run_d = stall_run_q;
    timeout_d   = timeout_q;
    exit_d      = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    // While rst is high the outputs must show the RUN defaults regardless of inputs.
    if (!rst) begin
      unique case (state_q)
        RUN, STALL: begin
          if (xfer_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_inc   = 1'b1;
            stall_run_d = '0;
            if (FLUSH_CYCLES > 1) begin
              state_d     = FLUSH;
              flush_cnt_d = FlushReload;
            end else begin
              state_d = RUN;
            end
          end else if (halt_id && !exit_q) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_run_d = '0;
            state_d     = HALT;
          end else if (hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            stall_inc   = 1'b1;
            state_d     = STALL;
            if (stall_run_q < StallLimit) begin
              stall_run_d = stall_run_q + 3'd1;
            end
            if (stall_run_d == StallLimit) begin
              timeout_d = 1'b1;
            end
          end else begin
            stall_run_d = '0;
            state_d     = RUN;
          end
        end
        FLUSH: begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (xfer_taken) begin
            flush_inc   = 1'b1;
            flush_cnt_d = FlushReload;
          end else if (flush_cnt_q <= 2'd1) begin
            flush_cnt_d = '0;
            state_d     = RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 2'd1;
          end
        end
        HALT: begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          halted      = 1'b1;
          if (PC_update) begin
            state_d = RUN;
            exit_d  = 1'b1;
          end
        end
      endcase
    end
  end

  assign stall_timeout = timeout_q;

  sat_counter #(
    .W(PERF_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(stall_inc),
    .clr(perf_clr),
    .cnt(stall_cycles)
  );

  sat_counter #(
    .W(PERF_W)
  ) u_flush_cnt (
    .clk(clk),
    .rst(rst),
    .inc(flush_inc),
    .clr(perf_clr),
    .cnt(flush_count)
  );

endmodule
